// File: rtl/fighter_motion_if.sv
// Key/frame inputs and sprite position/artwork-select outputs of one fighter.
// The master side drives the keys and frame pulse; the slave side is the motion controller.
interface fighter_motion_if;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic       facing;
    logic [1:0] anim_frame;
    logic [1:0] state;

    modport master (
        output frame_tick, key_left, key_right, key_jump,
        input  BallX, BallY, facing, anim_frame, state
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_jump,
        output BallX, BallY, facing, anim_frame, state
    );
endinterface

// File: rtl/fighter_motion.sv
// Per-fighter motion controller: walking, jumping, gravity and screen bounds,
// updated once per video frame; jump key edges are latched every pixel clock.
module fighter_motion #(
    parameter int unsigned START_X    = 100,
    parameter int unsigned GROUND_Y   = 400,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 640,
    parameter int unsigned SPRITE_W   = 40,
    parameter int unsigned WALK_SPEED = 2,
    parameter int unsigned JUMP_VEL   = 12,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MAX_FALL   = 12,
    parameter int unsigned ANIM_DIV   = 8
) (
    input logic             vga_clk,
    input logic             Reset,
    fighter_motion_if.slave bus
);
    localparam int unsigned XW      = 10;
    localparam int unsigned YSW     = 11;
    localparam int unsigned VW      = 6;
    localparam int unsigned X_RIGHT = X_MAX - SPRITE_W;
    localparam int unsigned CW      = ($clog2(ANIM_DIV) > 0) ? $clog2(ANIM_DIV) : 1;

    localparam logic signed [VW-1:0]  VY_LAUNCH  = VW'(-int'(JUMP_VEL));
    localparam logic signed [VW:0]    GRAVITY_S  = (VW+1)'(GRAVITY);
    localparam logic signed [VW:0]    MAX_FALL_S = (VW+1)'(MAX_FALL);
    localparam logic signed [YSW-1:0] GROUND_S   = YSW'(GROUND_Y);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } motion_state_t;

    motion_state_t         state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [XW-1:0]         y_q, y_d;
    logic signed [VW-1:0]  vy_q, vy_d;
    logic                  facing_q, facing_d;
    logic [1:0]            anim_q, anim_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  kj_q;
    logic                  jump_req_q;

    logic                  dir_l, dir_r;
    logic                  grounded, launch, vert_upd, air_d;
    logic signed [VW-1:0]  vy_eff;
    logic signed [YSW-1:0] ynew;
    logic signed [VW:0]    vy_grav;

    assign dir_l    = bus.key_left & ~bus.key_right;
    assign dir_r    = bus.key_right & ~bus.key_left;
    assign grounded = (state_q == IDLE) || (state_q == WALK);
    assign launch   = grounded & jump_req_q;
    assign vert_upd = ~grounded | launch;
    assign vy_eff   = launch ? VY_LAUNCH : vy_q;
    assign ynew     = $signed({1'b0, y_q}) + YSW'(vy_eff);
    assign vy_grav  = (VW+1)'(vy_eff) + GRAVITY_S;

    // Jump request: set on any key_jump rising edge, dropped by the next frame tick.
    // An edge coinciding with a tick wins so it carries over to the following tick.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            kj_q       <= 1'b0;
            jump_req_q <= 1'b0;
        end else begin
            kj_q <= bus.key_jump;
            if (bus.key_jump && !kj_q) begin
                jump_req_q <= 1'b1;
            end else if (bus.frame_tick) begin
                jump_req_q <= 1'b0;
            end
        end
    end

    // State register: everything else only moves on frame ticks
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            x_q      <= XW'(START_X);
            y_q      <= XW'(GROUND_Y);
            vy_q     <= '0;
            facing_q <= 1'b1;
            anim_q   <= '0;
            cnt_q    <= '0;
        end else if (bus.frame_tick) begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            facing_q <= facing_d;
            anim_q   <= anim_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state; the airborne phase follows the velocity applied this frame
    always_comb begin
        state_d = state_q;
        air_d   = vert_upd && (ynew < GROUND_S);
        if (air_d) begin
            state_d = vy_eff[VW-1] ? JUMP : FALL;
        end else begin
            state_d = (dir_l || dir_r) ? WALK : IDLE;
        end
    end

    // Next position, velocity, facing and walk animation
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        facing_d = facing_q;
        anim_d   = anim_q;
        cnt_d    = cnt_q;

        if (dir_l) begin
            facing_d = 1'b0;
            if ({1'b0, x_q} < (XW+1)'(X_MIN + WALK_SPEED)) begin
                x_d = XW'(X_MIN);
            end else begin
                x_d = x_q - XW'(WALK_SPEED);
            end
        end else if (dir_r) begin
            facing_d = 1'b1;
            if (((XW+1)'(x_q) + (XW+1)'(WALK_SPEED)) > (XW+1)'(X_RIGHT)) begin
                x_d = XW'(X_RIGHT);
            end else begin
                x_d = x_q + XW'(WALK_SPEED);
            end
        end

        if (vert_upd) begin
            if (ynew >= GROUND_S) begin
                y_d  = XW'(GROUND_Y);
                vy_d = '0;
            end else if (ynew[YSW-1]) begin
                y_d  = '0;
                vy_d = '0;
            end else begin
                y_d  = XW'(ynew);
                vy_d = (vy_grav > MAX_FALL_S) ? VW'(MAX_FALL) : VW'(vy_grav);
            end
        end

        if (state_d == WALK) begin
            if (cnt_q == CW'(ANIM_DIV - 1)) begin
                cnt_d  = '0;
                anim_d = anim_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = '0;
            anim_d = '0;
        end
    end

    assign bus.BallX      = x_q;
    assign bus.BallY      = y_q;
    assign bus.facing     = facing_q;
    assign bus.anim_frame = anim_q;
    assign bus.state      = 2'(state_q);
endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: directed table of walk scenarios, hand-written jump/reset
// sequences and a randomized run, all compared against an integer frame-level model.
module tb_fighter_motion;
    localparam int START_X    = 100;
    localparam int GROUND_Y   = 400;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 640;
    localparam int SPRITE_W   = 40;
    localparam int WALK_SPEED = 2;
    localparam int JUMP_VEL   = 12;
    localparam int GRAVITY    = 1;
    localparam int MAX_FALL   = 12;
    localparam int ANIM_DIV   = 8;

    logic vga_clk = 1'b0;
    logic Reset;

    fighter_motion_if bus();

    fighter_motion dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        bit    kl;
        bit    kr;
        int    ticks;
        int    x, y, f, a, s;
        string name;
    } row_t;

    row_t rows[$];

    bit kl, kr, kj;
    int n_vec, n_err;

    // Frame-level model: position, velocity, phase, facing, consecutive walk ticks
    int mx, my, mvy, mst, mf, mw;
    bit mreq, mkjp;

    function automatic logic [24:0] pack(input int x, input int y, input int f, input int a, input int s);
        return {10'(x), 10'(y), 1'(f), 2'(a), 2'(s)};
    endfunction

    function automatic logic [24:0] actual();
        return {bus.BallX, bus.BallY, bus.facing, bus.anim_frame, bus.state};
    endfunction

    function automatic logic [24:0] expected();
        return pack(mx, my, mf, (mw / ANIM_DIV) % 4, mst);
    endfunction

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got x=%0d y=%0d facing=%0d anim=%0d state=%0d, want x=%0d y=%0d facing=%0d anim=%0d state=%0d",
                     name, $time, act[24:15], act[14:5], act[4], act[3:2], act[1:0],
                     exp[24:15], exp[14:5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic model_reset();
        mx = START_X; my = GROUND_Y; mvy = 0; mst = 0; mf = 1; mw = 0;
        mreq = 1'b0; mkjp = 1'b0;
    endtask

    task automatic model_step(input bit tick);
        bit rise, launch, air;
        int dir, veff, ynew;
        rise = kj && !mkjp;
        if (tick) begin
            dir = (kr && !kl) ? 1 : ((kl && !kr) ? -1 : 0);
            if (dir < 0) begin
                mx = (mx < X_MIN + WALK_SPEED) ? X_MIN : mx - WALK_SPEED;
                mf = 0;
            end else if (dir > 0) begin
                mx = (mx + WALK_SPEED > X_MAX - SPRITE_W) ? X_MAX - SPRITE_W : mx + WALK_SPEED;
                mf = 1;
            end
            launch = (mst <= 1) && mreq;
            air    = 1'b0;
            veff   = mvy;
            if (mst >= 2 || launch) begin
                veff = launch ? -JUMP_VEL : mvy;
                ynew = my + veff;
                mvy  = (veff + GRAVITY < MAX_FALL) ? veff + GRAVITY : MAX_FALL;
                if (ynew >= GROUND_Y) begin
                    my = GROUND_Y; mvy = 0;
                end else if (ynew < 0) begin
                    my = 0; mvy = 0; air = 1'b1;
                end else begin
                    my = ynew; air = 1'b1;
                end
            end
            if (air) mst = (veff < 0) ? 2 : 3;
            else     mst = (dir != 0) ? 1 : 0;
            mw = (mst == 1) ? mw + 1 : 0;
        end
        if (rise)      mreq = 1'b1;
        else if (tick) mreq = 1'b0;
        mkjp = kj;
    endtask

    // One clock: drive at negedge, sample just after the active edge
    task automatic step(input bit tick);
        @(negedge vga_clk);
        bus.frame_tick = tick;
        bus.key_left   = kl;
        bus.key_right  = kr;
        bus.key_jump   = kj;
        @(posedge vga_clk);
        model_step(tick);
        #1;
        check("model", actual(), expected());
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic add_row(input bit l, input bit r, input int n, input int x, input int y,
                           input int f, input int a, input int s, input string name);
        row_t rw;
        rw.kl = l; rw.kr = r; rw.ticks = n;
        rw.x = x; rw.y = y; rw.f = f; rw.a = a; rw.s = s; rw.name = name;
        rows.push_back(rw);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        kl = 0; kr = 0; kj = 0;
        bus.frame_tick = 1'b0;
        bus.key_left   = 1'b0;
        bus.key_right  = 1'b0;
        bus.key_jump   = 1'b0;
        Reset = 1'b1;

        add_row(0, 0, 10,  100, 400, 1, 0, 0, "idle10");
        add_row(1, 0, 50,  0,   400, 0, 2, 1, "left50");
        add_row(1, 0, 10,  0,   400, 0, 3, 1, "left60_clamp");
        add_row(0, 0, 1,   0,   400, 0, 0, 0, "idle_gap");
        add_row(0, 1, 300, 600, 400, 1, 1, 1, "right300");
        add_row(0, 1, 8,   600, 400, 1, 2, 1, "right_clamp");
        add_row(1, 1, 1,   600, 400, 1, 0, 0, "both_keys");

        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_values", actual(), pack(100, 400, 1, 0, 0));
        @(negedge vga_clk);
        Reset = 1'b0;
        model_reset();

        foreach (rows[i]) begin
            kl = rows[i].kl;
            kr = rows[i].kr;
            tick_n(rows[i].ticks);
            check(rows[i].name, actual(),
                  pack(rows[i].x, rows[i].y, rows[i].f, rows[i].a, rows[i].s));
        end

        // Full jump arc from x=600 with a second, ignored press mid-air
        kl = 0; kr = 0;
        kj = 1; step(1'b0);
        kj = 0; step(1'b0);
        for (int t = 1; t <= 26; t++) begin
            if (t == 8) begin
                kj = 1; step(1'b0);
                kj = 0;
            end
            step(1'b0);
            step(1'b1);
            if (t == 1)  check("arc_t1",  actual(), pack(600, 388, 1, 0, 2));
            if (t == 12) check("arc_t12", actual(), pack(600, 322, 1, 0, 2));
            if (t == 13) check("arc_t13", actual(), pack(600, 322, 1, 0, 3));
            if (t == 24) check("arc_t24", actual(), pack(600, 388, 1, 0, 3));
            if (t == 25) check("arc_t25", actual(), pack(600, 400, 1, 0, 0));
            if (t == 26) check("arc_no_rebuffer", actual(), pack(600, 400, 1, 0, 0));
        end

        // Both keys while walking right, with a jump edge on the tick cycle itself
        kl = 1; kr = 0; tick_n(3);
        kl = 0; kr = 1; tick_n(2);
        check("walk_right", actual(), pack(598, 400, 1, 0, 1));
        kl = 1; kr = 1;
        step(1'b0);
        kj = 1; step(1'b1);
        check("both_jump_same_tick", actual(), pack(598, 400, 1, 0, 0));
        kl = 0; kr = 0;
        tick_n(1);
        check("jump_next_tick", actual(), pack(598, 388, 1, 0, 2));
        kj = 0;
        tick_n(24);
        check("landed_after_late_jump", actual(), pack(598, 400, 1, 0, 0));

        // Reset mid-jump, then a clean arc from the reset position
        kj = 1; step(1'b0);
        kj = 0; tick_n(6);
        check("pre_reset_t6", actual(), pack(598, 343, 1, 0, 2));
        @(negedge vga_clk);
        bus.frame_tick = 1'b0;
        bus.key_jump   = 1'b0;
        #2 Reset = 1'b1;
        #1 check("async_reset", actual(), pack(100, 400, 1, 0, 0));
        @(negedge vga_clk);
        Reset = 1'b0;
        model_reset();
        kj = 1; step(1'b0);
        kj = 0; step(1'b0);
        for (int t = 1; t <= 25; t++) begin
            step(1'b0);
            step(1'b1);
            if (t == 1)  check("rearc_t1",  actual(), pack(100, 388, 1, 0, 2));
            if (t == 13) check("rearc_t13", actual(), pack(100, 322, 1, 0, 3));
            if (t == 25) check("rearc_t25", actual(), pack(100, 400, 1, 0, 0));
        end

        // Randomized keys, jump toggles and tick spacing
        for (int i = 0; i < 1500; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                if ($urandom % 6 == 0) kj = ~kj;
                step(1'b0);
            end
            if ($urandom % 8 == 0) kl = 1'($urandom % 2);
            if ($urandom % 8 == 0) kr = 1'($urandom % 2);
            if ($urandom % 6 == 0) kj = ~kj;
            step(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fighter_motion.md
# fighter_motion

Per-fighter motion controller that computes the sprite's top-left screen position once per video frame from player key inputs. It models walking, jumping, gravity and screen bounds. Its BallX/BallY outputs feed the sprite renderer directly. It also supplies facing, animation-frame and state outputs that the renderer uses to select ROM artwork.

## Interface
Parameters:
- START_X, 100: X position after reset.
- GROUND_Y, 400: Y of the sprite top-left when standing on the floor.
- X_MIN, 0: leftmost legal BallX.
- X_MAX, 640: right screen edge; the rightmost legal BallX is X_MAX-SPRITE_W.
- SPRITE_W, 40: sprite width in pixels.
- WALK_SPEED, 2: pixels moved per frame while walking.
- JUMP_VEL, 12: initial upward speed in pixels/frame.
- GRAVITY, 1: speed added each frame while airborne.
- MAX_FALL, 12: terminal downward speed.
- ANIM_DIV, 8: frames per walk animation step.

Ports:
- vga_clk  in  1  pixel clock; the only clock in the block.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, issued by the VGA controller at vsync.
- key_left  in  1  level, held while the left key is down.
- key_right  in  1  level, held while the right key is down.
- key_jump  in  1  level, held while the jump key is down.
- BallX  out  10  sprite top-left X.
- BallY  out  10  sprite top-left Y.
- facing  out  1  1 = facing right, 0 = facing left.
- anim_frame  out  2  walk-cycle frame index.
- state  out  2  0 = IDLE, 1 = WALK, 2 = JUMP, 3 = FALL.

## Operation
Reset values:
- BallX=START_X, BallY=GROUND_Y.
- Vertical velocity vy=0, state=IDLE, facing=1, anim_frame=0.
- Animation counter and jump latch cleared.

Jump latch:
- A rising edge of key_jump, detected every vga_clk, sets jump_req.
- jump_req is consumed and cleared at the next frame_tick whether or not it was honoured. A jump pressed while airborne is therefore discarded, not buffered.
- Holding key_jump produces exactly one request.

All other state changes happen only on cycles where frame_tick=1.

Horizontal update:
- dir = right if only key_right is high, left if only key_left is high, otherwise none. Both keys or neither means no movement and facing is unchanged.
- Left: BallX = X_MIN if BallX < X_MIN+WALK_SPEED, else BallX-WALK_SPEED. facing=0.
- Right: BallX = X_MAX-SPRITE_W if BallX+WALK_SPEED > X_MAX-SPRITE_W, else BallX+WALK_SPEED. facing=1.
- Horizontal movement is applied in every state, including the air.

Vertical update:
- launch = grounded (state IDLE or WALK) and jump_req.
- vy_eff = -JUMP_VEL if launch, otherwise vy.
- Only when airborne or launching:
  - Ynew = BallY + vy_eff, computed as signed 11-bit.
  - vy = min(vy_eff+GRAVITY, MAX_FALL).
- Landing: if Ynew >= GROUND_Y, then BallY=GROUND_Y, vy=0, and the block is grounded.
- Ceiling: if Ynew < 0, then BallY=0 and vy=0 (the block falls from the next frame).
- Otherwise BallY=Ynew.
- vy is 6-bit signed.

State after each tick:
- Airborne with vy<0: JUMP.
- Airborne with vy>=0: FALL.
- Grounded with dir≠none: WALK.
- Grounded with dir=none: IDLE.

Animation:
- In WALK, the counter increments each tick. When it reaches ANIM_DIV-1 it resets to 0 and anim_frame advances, wrapping 3 to 0.
- Any other state forces the counter and anim_frame to 0.

## Timing
- All outputs are registered and change on the vga_clk edge that samples frame_tick=1. Outputs are valid from the following cycle and hold for the rest of the frame, so the renderer sees stable positions across the whole active region.
- A key change becomes visible within 1 tick (if asserted before that tick).
- A jump edge counts for tick N only if it occurs at least 1 cycle before tick N. An edge in the same cycle as tick N is latched and applies to tick N+1.
- Reset asserted mid-jump immediately and asynchronously forces the reset values.
- Between ticks, frame_tick=0 holds all outputs except the internal jump_req.

## Test plan
- Reset, then 10 ticks with no keys -> BallX=100, BallY=400, state=0, facing=1, anim_frame=0 throughout.
- Hold key_left for 60 ticks from BallX=100 -> BallX decreases by 2 per tick, reaches 0 at tick 50 and stays 0. facing=0, state=1.
- Hold key_right for 300 ticks -> BallX clamps at 600. anim_frame steps every 8 ticks through 0,1,2,3,0.
- Pulse key_jump, then send 25 ticks -> BallY=388 at tick 1, 322 at ticks 12-13, back to 400 at tick 25.
  - state=2 for ticks 1-12, state=3 for ticks 13-24, IDLE at tick 25.
  - A second key_jump pulse during ticks 5-20 is ignored.
- Press key_left and key_right together while walking right -> no X change, facing stays 1, state=0.
  - Also press key_jump in the same cycle as a tick -> the jump starts on the following tick, not that one.
- Assert Reset at tick 6 of a jump, mid-cycle -> BallY=400, state=0 and vy=0 immediately; the next jump reproduces the full 25-tick arc.
